// File: rtl/mem_fill_ctrl.sv
// ============================================================================
// Module      : mem_fill_ctrl
// Description : Miss-fill queue and memory request/response sequencer that
//               returns filled lines to cache lookup. Optional response
//               watchdog enabled by MEM_FILL_TIMEOUT_EN.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module mem_fill_ctrl #(
  parameter int QDEPTH  = 2,
  parameter int TIMEOUT = 64
) (
  input  logic         clk_i,
  input  logic         rsn_i,
  input  logic         rqst_i,
  input  logic [19:0]  rqst_addr_i,
  output logic         busy_o,
  output logic         ovf_o,
  output logic         mem_req_valid_o,
  input  logic         mem_req_ready_i,
  output logic [15:0]  mem_req_addr_o,
  input  logic         mem_resp_valid_i,
  input  logic [127:0] mem_resp_data_i,
  output logic         fill_ready_o,
  output logic [19:0]  fill_addr_o,
  output logic [127:0] fill_data_o,
  output logic         timeout_o
);

  localparam int c_PTR_W = $clog2(QDEPTH);

  typedef enum logic [1:0] {
    S_IDLE      = 2'd0,
    S_ISSUE     = 2'd1,
    S_WAIT_RESP = 2'd2,
    S_DELIVER   = 2'd3
  } state_t;

  state_t             r_state;
  logic [15:0]        r_q [QDEPTH];
  logic [c_PTR_W-1:0] r_head;
  logic [c_PTR_W-1:0] r_tail;
  logic [c_PTR_W:0]   r_count;
  logic [15:0]        r_infl;
  logic               r_infl_vld;
  logic               r_req_valid;
  logic [15:0]        r_req_addr;
  logic               r_fill;
  logic [19:0]        r_fill_addr;
  logic [127:0]       r_fill_data;
  logic               r_ovf;

  logic [15:0]        w_line;
  logic [15:0]        w_head_line;
  logic [QDEPTH-1:0]  w_match;
  logic               w_dup;
  logic               w_full;
  logic               w_hs;
  logic               w_pop;
  logic               w_push;
  logic               w_drop_full;
  logic               w_reissue;
  logic               w_unused;

  assign w_line      = rqst_addr_i[19:4];
  assign w_head_line = r_q[r_head];
  assign w_full      = (r_count == (c_PTR_W+1)'(QDEPTH));

  // A slot is live when its distance from the head is below the occupancy.
  for (genvar gi = 0; gi < QDEPTH; gi++) begin : g_match
    logic [c_PTR_W-1:0] w_off;
    assign w_off       = c_PTR_W'(gi) - r_head;
    assign w_match[gi] = ({1'b0, w_off} < r_count) && (r_q[gi] == w_line);
  end

  assign w_dup       = (|w_match) || (r_infl_vld && (r_infl == w_line));
  assign w_hs        = (r_state == S_ISSUE) && mem_req_ready_i;
  assign w_pop       = w_hs && !w_reissue;
  assign w_push      = rqst_i && !w_dup && (!w_full || w_pop);
  assign w_drop_full = rqst_i && !w_dup && w_full && !w_pop;

`ifdef MEM_FILL_TIMEOUT_EN
  localparam int c_CNT_W = ($clog2(TIMEOUT + 1) > 8) ? $clog2(TIMEOUT + 1) : 8;

  logic [c_CNT_W-1:0] r_cnt;
  logic               r_tmo;
  logic               r_reissue;
  logic               w_tmo_hit;

  assign w_tmo_hit = (r_state == S_WAIT_RESP) && !mem_resp_valid_i &&
                     (r_cnt == c_CNT_W'(TIMEOUT - 1));
  assign w_reissue = r_reissue;
  assign timeout_o = r_tmo;
  assign w_unused  = ^rqst_addr_i[3:0];

  always_ff @(posedge clk_i or negedge rsn_i) begin
    if (!rsn_i) begin
      r_cnt     <= '0;
      r_tmo     <= 1'b0;
      r_reissue <= 1'b0;
    end else if (w_hs) begin
      r_cnt     <= '0;
      r_reissue <= 1'b0;
    end else if (w_tmo_hit) begin
      r_tmo     <= 1'b1;
      r_reissue <= 1'b1;
    end else if (r_state == S_WAIT_RESP && !mem_resp_valid_i) begin
      r_cnt     <= r_cnt + c_CNT_W'(1);
    end
  end
`else
  assign w_reissue = 1'b0;
  assign timeout_o = 1'b0;
  assign w_unused  = ^{rqst_addr_i[3:0], 32'(TIMEOUT)};
`endif

  // Storage needs no reset: occupancy alone decides which slots are live.
  always_ff @(posedge clk_i) begin
    if (w_push) r_q[r_tail] <= w_line;
  end

  always_ff @(posedge clk_i or negedge rsn_i) begin
    if (!rsn_i) begin
      r_head  <= '0;
      r_tail  <= '0;
      r_count <= '0;
    end else begin
      if (w_push) r_tail <= r_tail + c_PTR_W'(1);
      if (w_pop)  r_head <= r_head + c_PTR_W'(1);
      if (w_push && !w_pop)      r_count <= r_count + (c_PTR_W+1)'(1);
      else if (w_pop && !w_push) r_count <= r_count - (c_PTR_W+1)'(1);
    end
  end

  always_ff @(posedge clk_i or negedge rsn_i) begin
    if (!rsn_i) begin
      r_state     <= S_IDLE;
      r_req_valid <= 1'b0;
      r_req_addr  <= '0;
      r_infl      <= '0;
      r_infl_vld  <= 1'b0;
      r_fill      <= 1'b0;
      r_fill_addr <= '0;
      r_fill_data <= '0;
      r_ovf       <= 1'b0;
    end else begin
      r_fill <= 1'b0;
      if (w_drop_full) r_ovf <= 1'b1;
      case (r_state)
        S_IDLE, S_DELIVER: begin
          if (r_count != '0) begin
            r_state     <= S_ISSUE;
            r_req_valid <= 1'b1;
            r_req_addr  <= w_head_line;
          end else begin
            r_state     <= S_IDLE;
          end
        end
        S_ISSUE: begin
          if (mem_req_ready_i) begin
            r_state     <= S_WAIT_RESP;
            r_req_valid <= 1'b0;
            r_infl_vld  <= 1'b1;
            if (!w_reissue) r_infl <= w_head_line;
          end
        end
        S_WAIT_RESP: begin
          if (mem_resp_valid_i) begin
            r_state     <= S_DELIVER;
            r_fill      <= 1'b1;
            r_fill_addr <= {r_infl, 4'b0000};
            r_fill_data <= mem_resp_data_i;
            r_infl_vld  <= 1'b0;
          end
`ifdef MEM_FILL_TIMEOUT_EN
          else if (w_tmo_hit) begin
            r_state     <= S_ISSUE;
            r_req_valid <= 1'b1;
            r_req_addr  <= r_infl;
          end
`endif
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

  assign busy_o          = w_full;
  assign ovf_o           = r_ovf;
  assign mem_req_valid_o = r_req_valid;
  assign mem_req_addr_o  = r_req_addr;
  assign fill_ready_o    = r_fill;
  assign fill_addr_o     = r_fill_addr;
  assign fill_data_o     = r_fill_data;

endmodule

`default_nettype wire

// File: tb/tb_mem_fill_ctrl.sv
// ============================================================================
// Module      : tb_mem_fill_ctrl
// Description : Self-checking bench for mem_fill_ctrl: vector table, directed
//               corner sequences and randomized traffic against a queue model.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_mem_fill_ctrl;

  localparam int QDEPTH  = 2;
  localparam int TIMEOUT = 8;

  logic         clk = 1'b0;
  logic         rsn = 1'b0;
  logic         rqst = 1'b0;
  logic [19:0]  rqst_addr = '0;
  logic         busy, ovf, req_valid, fill_ready, tmo;
  logic         req_ready = 1'b0;
  logic [15:0]  req_addr;
  logic         resp_valid = 1'b0;
  logic [127:0] resp_data = '0;
  logic [19:0]  fill_addr;
  logic [127:0] fill_data;

  int checks   = 0;
  int failures = 0;

  mem_fill_ctrl #(.QDEPTH(QDEPTH), .TIMEOUT(TIMEOUT)) dut (
    .clk_i(clk), .rsn_i(rsn), .rqst_i(rqst), .rqst_addr_i(rqst_addr),
    .busy_o(busy), .ovf_o(ovf), .mem_req_valid_o(req_valid),
    .mem_req_ready_i(req_ready), .mem_req_addr_o(req_addr),
    .mem_resp_valid_i(resp_valid), .mem_resp_data_i(resp_data),
    .fill_ready_o(fill_ready), .fill_addr_o(fill_addr),
    .fill_data_o(fill_data), .timeout_o(tmo)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%h expected=%h", name, act, exp);
    end
  endtask

  task automatic cyc();
    @(posedge clk);
    @(negedge clk);
  endtask

  // Reference model: pending lines as a queue plus the current transaction phase.
  logic [15:0]  mq[$];
  bit           m_issue, m_wait, m_fill, m_reissue, m_ovf, m_tmo;
  logic [15:0]  m_req_addr, m_infl;
  logic [19:0]  m_faddr;
  logic [127:0] m_fdata;
  int           m_cnt;

  task automatic model_reset();
    mq.delete();
    m_issue = 0; m_wait = 0; m_fill = 0; m_reissue = 0; m_ovf = 0; m_tmo = 0;
    m_req_addr = '0; m_infl = '0; m_faddr = '0; m_fdata = '0; m_cnt = 0;
  endtask

  task automatic model_step(input bit rq, input logic [19:0] a, input bit rdy,
                            input bit rv, input logic [127:0] d);
    logic [15:0] line;
    int  old_size;
    bit  dup, pop, was_fill;
    line     = a[19:4];
    old_size = mq.size();
    dup      = (m_wait || (m_issue && m_reissue)) && (line == m_infl);
    foreach (mq[i]) if (mq[i] == line) dup = 1;
    pop      = m_issue && rdy && !m_reissue;
    was_fill = m_fill;
    m_fill   = 0;
    if (m_issue) begin
      if (rdy) begin
        if (!m_reissue) m_infl = mq[0];
        m_issue = 0; m_wait = 1; m_reissue = 0; m_cnt = 0;
      end
    end else if (m_wait) begin
      if (rv) begin
        m_wait = 0; m_fill = 1; m_faddr = {m_infl, 4'h0}; m_fdata = d;
      end else begin
        m_cnt++;
`ifdef MEM_FILL_TIMEOUT_EN
        if (m_cnt == TIMEOUT) begin
          m_tmo = 1; m_wait = 0; m_issue = 1; m_reissue = 1; m_req_addr = m_infl;
        end
`endif
      end
    end else if (old_size > 0) begin
      m_issue = 1; m_req_addr = mq[0];
    end
    if (was_fill && m_issue) m_req_addr = mq[0];
    if (pop) void'(mq.pop_front());
    if (rq && !dup) begin
      if (old_size < QDEPTH || pop) mq.push_back(line);
      else m_ovf = 1;
    end
  endtask

  task automatic do_reset();
    @(negedge clk);
    rsn = 1'b0; rqst = 0; req_ready = 0; resp_valid = 0; resp_data = '0; rqst_addr = '0;
    #1;
    chk("rst_busy", busy, 0);         chk("rst_ovf", ovf, 0);
    chk("rst_req_valid", req_valid, 0); chk("rst_req_addr", req_addr, 0);
    chk("rst_fill_ready", fill_ready, 0); chk("rst_fill_addr", fill_addr, 0);
    chk("rst_fill_data", fill_data, 0); chk("rst_timeout", tmo, 0);
    @(negedge clk);
    @(negedge clk);
    rsn = 1'b1;
    model_reset();
  endtask

  typedef struct {
    bit           rst, rq, rdy, rv;
    logic [19:0]  addr;
    logic [127:0] rdata;
    bit           e_busy, e_ovf, e_vld, e_fill;
    logic [15:0]  e_raddr;
    logic [19:0]  e_faddr;
    logic [127:0] e_fdata;
  } vec_t;

  function automatic vec_t mk(bit rst, bit rq, logic [19:0] a, bit rdy, bit rv,
                              logic [127:0] d, bit eb, bit eo, bit ev,
                              logic [15:0] ea, bit ef, logic [19:0] efa,
                              logic [127:0] efd);
    vec_t v;
    v.rst = rst; v.rq = rq; v.addr = a; v.rdy = rdy; v.rv = rv; v.rdata = d;
    v.e_busy = eb; v.e_ovf = eo; v.e_vld = ev; v.e_raddr = ea;
    v.e_fill = ef; v.e_faddr = efa; v.e_fdata = efd;
    return v;
  endfunction

  localparam logic [127:0] A5 = {16{8'hA5}};
  localparam logic [127:0] D1 = {16{8'h11}};
  localparam logic [127:0] D2 = {16{8'h22}};
  localparam logic [127:0] DX = {16{8'h99}};

  vec_t vec[16];

  initial begin : main
    int fills, vseen, tk;
    logic [19:0] ra;

    //           rst rq addr      rdy rv data  busy ovf vld raddr    fill faddr     fdata
    vec[0]  = mk(1, 1, 20'h12345, 1, 0, '0,  0, 0, 0, 16'h0000, 0, 20'h00000, '0);
    vec[1]  = mk(0, 0, 20'h00000, 1, 0, '0,  0, 0, 1, 16'h1234, 0, 20'h00000, '0);
    vec[2]  = mk(0, 0, 20'h00000, 1, 0, '0,  0, 0, 0, 16'h0000, 0, 20'h00000, '0);
    vec[3]  = mk(0, 0, 20'h00000, 1, 1, A5,  0, 0, 0, 16'h0000, 1, 20'h12340, A5);
    vec[4]  = mk(0, 0, 20'h00000, 1, 0, '0,  0, 0, 0, 16'h0000, 0, 20'h12340, A5);
    vec[5]  = mk(0, 0, 20'h00000, 1, 1, DX,  0, 0, 0, 16'h0000, 0, 20'h12340, A5);
    vec[6]  = mk(1, 1, 20'h00010, 0, 0, '0,  0, 0, 0, 16'h0000, 0, 20'h00000, '0);
    vec[7]  = mk(0, 1, 20'h00020, 0, 0, '0,  1, 0, 1, 16'h0001, 0, 20'h00000, '0);
    vec[8]  = mk(0, 1, 20'h00030, 0, 0, '0,  1, 1, 1, 16'h0001, 0, 20'h00000, '0);
    vec[9]  = mk(0, 0, 20'h00000, 1, 0, '0,  0, 1, 0, 16'h0000, 0, 20'h00000, '0);
    vec[10] = mk(0, 0, 20'h00000, 1, 1, D1,  0, 1, 0, 16'h0000, 1, 20'h00010, D1);
    vec[11] = mk(0, 0, 20'h00000, 1, 1, DX,  0, 1, 1, 16'h0002, 0, 20'h00010, D1);
    vec[12] = mk(0, 0, 20'h00000, 1, 0, '0,  0, 1, 0, 16'h0000, 0, 20'h00010, D1);
    vec[13] = mk(0, 0, 20'h00000, 1, 1, D2,  0, 1, 0, 16'h0000, 1, 20'h00020, D2);
    vec[14] = mk(0, 0, 20'h00000, 1, 0, '0,  0, 1, 0, 16'h0000, 0, 20'h00020, D2);
    vec[15] = mk(0, 0, 20'h00000, 1, 0, '0,  0, 1, 0, 16'h0000, 0, 20'h00020, D2);

    for (int i = 0; i < 16; i++) begin
      if (vec[i].rst) do_reset();
      rqst = vec[i].rq; rqst_addr = vec[i].addr; req_ready = vec[i].rdy;
      resp_valid = vec[i].rv; resp_data = vec[i].rdata;
      cyc();
      chk($sformatf("v%0d_busy", i), busy, vec[i].e_busy);
      chk($sformatf("v%0d_ovf", i), ovf, vec[i].e_ovf);
      chk($sformatf("v%0d_req_valid", i), req_valid, vec[i].e_vld);
      if (vec[i].e_vld) chk($sformatf("v%0d_req_addr", i), req_addr, vec[i].e_raddr);
      chk($sformatf("v%0d_fill_ready", i), fill_ready, vec[i].e_fill);
      chk($sformatf("v%0d_fill_addr", i), fill_addr, vec[i].e_faddr);
      chk($sformatf("v%0d_fill_data", i), fill_data, vec[i].e_fdata);
    end
    rqst = 0; req_ready = 0; resp_valid = 0;

    // Duplicate of the in-flight line is dropped silently.
    do_reset();
    req_ready = 1; rqst = 1; rqst_addr = 20'h00450; cyc();
    rqst = 0; cyc(); cyc();
    rqst = 1; rqst_addr = 20'h0045C; cyc();
    rqst = 0;
    chk("dup_ovf", ovf, 0);
    chk("dup_busy", busy, 0);
    resp_valid = 1; resp_data = D1; cyc();
    resp_valid = 0;
    chk("dup_fill_ready", fill_ready, 1);
    chk("dup_fill_addr", fill_addr, 20'h00450);
    fills = 0; vseen = 0;
    for (int k = 0; k < 8; k++) begin
      cyc();
      if (fill_ready) fills++;
      if (req_valid) vseen++;
    end
    chk("dup_extra_fills", fills, 0);
    chk("dup_extra_reqs", vseen, 0);

    // Asynchronous reset while waiting for the response.
    do_reset();
    req_ready = 1; rqst = 1; rqst_addr = 20'h00770; cyc();
    rqst = 0; cyc(); cyc();
    rqst = 1; rqst_addr = 20'h00880; cyc();
    rqst = 0; req_ready = 0;
    #2 rsn = 0;
    #1;
    chk("arst_busy", busy, 0); chk("arst_req_valid", req_valid, 0);
    chk("arst_fill_ready", fill_ready, 0); chk("arst_timeout", tmo, 0);
    @(negedge clk);
    rsn = 1; req_ready = 1; resp_valid = 1; resp_data = D2;
    fills = 0; vseen = 0;
    for (int k = 0; k < 6; k++) begin
      cyc();
      if (fill_ready) fills++;
      if (req_valid) vseen++;
    end
    resp_valid = 0;
    chk("arst_no_fill", fills, 0);
    chk("arst_queue_empty", vseen, 0);
    chk("arst_fill_data", fill_data, 0);

    // Push coinciding with the handshake pop at occupancy 1.
    do_reset();
    rqst = 1; rqst_addr = 20'h00100; cyc();
    rqst = 0; cyc();
    chk("pp_valid", req_valid, 1);
    req_ready = 1; rqst = 1; rqst_addr = 20'h00200; cyc();
    req_ready = 0; rqst = 0;
    chk("pp_busy_after", busy, 0);
    rqst = 1; rqst_addr = 20'h00300; cyc();
    rqst = 0;
    chk("pp_busy_two", busy, 1);
    resp_valid = 1; resp_data = D1; cyc();
    resp_valid = 0;
    chk("pp_fill_addr", fill_addr, 20'h00100);
    cyc();
    chk("pp_next_valid", req_valid, 1);
    chk("pp_next_addr", req_addr, 16'h0020);

    // Withheld response: watchdog behaviour depends on the build.
    do_reset();
    req_ready = 1; rqst = 1; rqst_addr = 20'h00AB0; cyc();
    rqst = 0; cyc(); cyc();
    req_ready = 0;
`ifdef MEM_FILL_TIMEOUT_EN
    tk = 0;
    for (int k = 1; k <= 20; k++) begin
      cyc();
      if (tmo && tk == 0) tk = k;
      if (tk != 0) break;
    end
    chk("tmo_cycles", tk, 8);
    chk("tmo_reissue_valid", req_valid, 1);
    chk("tmo_reissue_addr", req_addr, 16'h00AB);
    req_ready = 1; cyc();
    req_ready = 0; resp_valid = 1; resp_data = A5; cyc();
    resp_valid = 0;
    chk("tmo_fill_addr", fill_addr, 20'h00AB0);
    chk("tmo_sticky", tmo, 1);
`else
    tk = 0; vseen = 0; fills = 0;
    for (int k = 0; k < 100; k++) begin
      cyc();
      if (tmo) tk++;
      if (req_valid) vseen++;
      if (fill_ready) fills++;
    end
    chk("notmo_timeout", tk, 0);
    chk("notmo_no_reissue", vseen, 0);
    chk("notmo_no_fill", fills, 0);
`endif

    // Randomized traffic against the reference model.
    do_reset();
    for (int n = 0; n < 3000; n++) begin
      chk("rnd_busy", busy, (mq.size() == QDEPTH));
      chk("rnd_ovf", ovf, m_ovf);
      chk("rnd_req_valid", req_valid, m_issue);
      if (m_issue) chk("rnd_req_addr", req_addr, m_req_addr);
      chk("rnd_fill_ready", fill_ready, m_fill);
      chk("rnd_fill_addr", fill_addr, m_faddr);
      chk("rnd_fill_data", fill_data, m_fdata);
      chk("rnd_timeout", tmo, m_tmo);
      ra = {16'($urandom_range(5)), 4'($urandom)};
      rqst       = ($urandom_range(99) < 45);
      rqst_addr  = ra;
      req_ready  = ($urandom_range(99) < 50);
      resp_valid = ($urandom_range(99) < 40);
      resp_data  = {$urandom, $urandom, $urandom, $urandom};
      model_step(rqst, rqst_addr, req_ready, resp_valid, resp_data);
      cyc();
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

`default_nettype wire

// File: doc/mem_fill_ctrl.md
Name: mem_fill_ctrl

Overview:
Miss-fill stage directly downstream of the cache lookup block.
- Accepts line-fill requests (rqst_to_mem / addr_to_mem from lookup) and queues them.
- Issues them one at a time to main memory over a valid/ready request channel and collects the single-beat 128-bit response.
- Returns the line to lookup and the data array as a one-cycle fill_ready pulse with the line address. Lookup's mem_data_ready_i and mem_addr_i are driven from that pulse and address.

Parameters:
QDEPTH, 2, request queue entries; power of 2, at least 2.
TIMEOUT, 64, response watchdog limit in cycles; used only with the optional feature.

Ports:
clk_i  in  1  clock, all state on rising edge
rsn_i  in  1  reset; asynchronous, active-low
rqst_i  in  1  fill request strobe from lookup, one cycle per request
rqst_addr_i  in  20  requested byte address; only bits [19:4] are used
busy_o  out  1  queue full; requester must not strobe rqst_i
ovf_o  out  1  sticky: request dropped because queue was full
mem_req_valid_o  out  1  memory request valid
mem_req_ready_i  in  1  memory accepts request
mem_req_addr_o  out  16  line address to memory (addr[19:4])
mem_resp_valid_i  in  1  memory response valid, single beat
mem_resp_data_i  in  128  response line data
fill_ready_o  out  1  one-cycle pulse: fill line available
fill_addr_o  out  20  filled line address, bits [3:0] = 0
fill_data_o  out  128  filled line data
timeout_o  out  1  sticky watchdog flag; tied 0 without the optional feature

Behaviour:
- Reset (rsn_i low, asynchronous): state IDLE; queue empty; all outputs 0 (busy_o, ovf_o, mem_req_valid_o, mem_req_addr_o, fill_ready_o, fill_addr_o, fill_data_o, timeout_o).
  - Reset mid-transaction discards the in-flight request and all queued entries.
  - A mem_resp_valid_i arriving after reset, in IDLE or ISSUE, is ignored.
- Enqueue: on rqst_i=1 at a rising edge, push line address rqst_addr_i[19:4] into the circular FIFO. Head and tail pointers wrap modulo QDEPTH.
- Duplicate suppression: drop the push, with no flag, if the line address equals any valid queued entry or the in-flight entry.
- Full: busy_o = (count == QDEPTH). A non-duplicate rqst_i while full is dropped and sets ovf_o, which stays set until reset.
- Simultaneous push and pop in one cycle is legal at any occupancy; count is unchanged.
- States:
  - IDLE: if the queue is non-empty, go to ISSUE next cycle.
  - ISSUE: mem_req_valid_o=1, mem_req_addr_o = queue head. Hold both stable until mem_req_ready_i=1. On the handshake, pop the head into the in-flight register and go to WAIT_RESP.
  - WAIT_RESP: mem_req_valid_o=0. On mem_resp_valid_i=1, register mem_resp_data_i into fill_data_o and {in-flight addr, 4'b0} into fill_addr_o, then go to DELIVER.
  - DELIVER: fill_ready_o=1 for exactly this one cycle. Next state is ISSUE if the queue is non-empty, else IDLE.
- fill_addr_o and fill_data_o hold their values until the next DELIVER.
- mem_resp_valid_i outside WAIT_RESP is ignored.
- Minimum latency:
  - rqst_i at edge N, into the queue.
  - Edge N+1: state moves to ISSUE.
  - mem_req_valid_o high during cycle N+1..N+2; with ready already high, handshake at edge N+2.
  - Response valid in the following cycle: captured at edge N+3.
  - fill_ready_o high during N+3..N+4.
- Throughput is one outstanding memory request at a time.

Optional Feature:
MEM_FILL_TIMEOUT_EN
- Defined:
  - An 8-bit-or-wider counter clears on entry to WAIT_RESP and increments each cycle while waiting.
  - When the counter reaches TIMEOUT without a response: set timeout_o (sticky until reset), then return to ISSUE and reissue the in-flight address ahead of the queue head. The queue is not popped again.
- Undefined: no counter; WAIT_RESP waits indefinitely; timeout_o is constant 0.

Test Plan:
1. Reset, then rqst_i with addr 0x12345; mem ready=1; response 1 cycle after handshake with data 0xA5..A5.
   Expect: mem_req_addr_o=0x1234; fill_ready_o pulses once, at edge N+3; fill_addr_o=0x12340; fill_data_o=0xA5..A5.
2. Three distinct requests (0x00010, 0x00020, 0x00030) on consecutive cycles with QDEPTH=2 and mem_req_ready_i held 0.
   Expect: the third is dropped, busy_o=1, ovf_o=1; after releasing ready, exactly two fills in order 0x00010, 0x00020.
3. Request 0x00450, then 0x0045C while the first is in flight.
   Expect: second dropped as duplicate, ovf_o stays 0, one fill for 0x00450.
4. Pulse rsn_i low during WAIT_RESP, then drive mem_resp_valid_i after release.
   Expect: all outputs 0, no fill_ready_o pulse, queue empty.
5. Push on the same cycle as an ISSUE handshake pop at count=1.
   Expect: count stays 1, and the next ISSUE carries the pushed address.
6. With MEM_FILL_TIMEOUT_EN and TIMEOUT=8, withhold the response.
   Expect: timeout_o rises 8 cycles after entering WAIT_RESP; mem_req_valid_o reasserts with the same address. Without the macro: timeout_o=0 and the block stays in WAIT_RESP.
